// File: rtl/load_use_scoreboard.sv
// Per-register countdown scoreboard that stalls ID while any read operand
// still waits on a multi-cycle producer, and drives the PC/IF-ID/ID-EXE controls.
module load_use_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int NSRC    = 2,
    parameter int LAT_W   = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ID_valid,
    input  logic [NSRC*REG_AW-1:0]   ID_src,
    input  logic [NSRC-1:0]          ID_srcRead,
    input  logic                     ID_dstWr,
    input  logic [REG_AW-1:0]        ID_dst,
    input  logic [LAT_W-1:0]         ID_lat,
    input  logic                     pipe_hold,
    input  logic                     pipe_flush,
    output logic                     IF_PCWr,
    output logic                     IF_IDWr,
    output logic                     IDEXE_Flush,
    output logic [REG_NUM-1:0]       busy_vec,
    output logic [31:0]              stall_cnt
);

    localparam int IDX_N = 2 ** REG_AW;

    logic [LAT_W-1:0]  cnt_q [REG_NUM];
    logic [LAT_W-1:0]  cnt_d [REG_NUM];
    logic [31:0]       stall_cnt_q;
    logic [31:0]       stall_cnt_d;

    logic [REG_NUM-1:0] busy;
    logic [IDX_N-1:0]   busy_ext;
    logic [REG_AW-1:0]  src_idx;
    logic [LAT_W-1:0]   dec_v;
    logic               hazard;
    logic               issue;
    logic               dst_wr_ok;

    always_comb begin
        busy = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    // Widen to the full index space so out-of-range sources read as idle.
    always_comb begin
        busy_ext = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy_ext[i] = busy[i];
        end
    end

    always_comb begin
        hazard  = 1'b0;
        src_idx = '0;
        for (int j = 0; j < NSRC; j++) begin
            src_idx = ID_src[j*REG_AW +: REG_AW];
            if (ID_srcRead[j] && (src_idx != '0) && busy_ext[src_idx]) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & ID_valid;
    end

    assign issue     = ID_valid & ~hazard & ~pipe_hold & ~pipe_flush;
    assign dst_wr_ok = issue & ID_dstWr & (ID_dst != '0);

    assign IF_PCWr     = ~(hazard | pipe_hold);
    assign IF_IDWr     = ~(hazard | pipe_hold);
    assign IDEXE_Flush = hazard & ~pipe_hold;
    assign busy_vec    = busy;
    assign stall_cnt   = stall_cnt_q;

    // A WAW re-write keeps the larger of the new latency and what remains.
    always_comb begin
        dec_v = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pipe_flush) begin
                cnt_d[i] = '0;
            end else if (!pipe_hold) begin
                dec_v    = (cnt_q[i] != '0) ? (cnt_q[i] - LAT_W'(1)) : '0;
                cnt_d[i] = dec_v;
                if (dst_wr_ok && (ID_dst == REG_AW'(i))) begin
                    cnt_d[i] = (ID_lat > dec_v) ? ID_lat : dec_v;
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !pipe_hold && !pipe_flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: load-use, long latency, r0, WAW,
// hold/flush and asynchronous reset scenarios with hand-computed expectations.
module tb_load_use_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ID_valid;
    logic [9:0]  ID_src;
    logic [1:0]  ID_srcRead;
    logic        ID_dstWr;
    logic [4:0]  ID_dst;
    logic [2:0]  ID_lat;
    logic        pipe_hold;
    logic        pipe_flush;
    logic        IF_PCWr;
    logic        IF_IDWr;
    logic        IDEXE_Flush;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    load_use_scoreboard dut (
        .clk         (clk),
        .resetn      (resetn),
        .ID_valid    (ID_valid),
        .ID_src      (ID_src),
        .ID_srcRead  (ID_srcRead),
        .ID_dstWr    (ID_dstWr),
        .ID_dst      (ID_dst),
        .ID_lat      (ID_lat),
        .pipe_hold   (pipe_hold),
        .pipe_flush  (pipe_flush),
        .IF_PCWr     (IF_PCWr),
        .IF_IDWr     (IF_IDWr),
        .IDEXE_Flush (IDEXE_Flush),
        .busy_vec    (busy_vec),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                         input logic [1:0] rd, input logic wr, input logic [4:0] d,
                         input logic [2:0] lat);
        ID_valid   = v;
        ID_src     = {s1, s0};
        ID_srcRead = rd;
        ID_dstWr   = wr;
        ID_dst     = d;
        ID_lat     = lat;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 3'd0);
        for (int k = 0; k < n; k++) cyc();
    endtask

    // Count cycles with IF_PCWr low while the current ID stays put; returns at
    // the negedge of the first non-stalled cycle.
    task automatic stall_run(input int idx, output int n, output int nflush,
                             output logic [7:0] hist);
        logic done;
        n = 0;
        nflush = 0;
        hist = '0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (k < 8) hist[k] = busy_vec[idx];
            if (IF_PCWr) begin
                done = 1'b1;
            end else begin
                n++;
                if (IDEXE_Flush) nflush++;
                cyc();
            end
        end
        if (!done) chk("stall_timeout", 32'd0, 32'd1);
    endtask

    int         n;
    int         nf;
    logic [7:0] hist;

    initial begin
        resetn     = 1'b1;
        pipe_hold  = 1'b0;
        pipe_flush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 3'd0);
        #1 resetn = 1'b0;
        #2;
        chk("rst_pcwr",  32'(IF_PCWr), 32'd1);
        chk("rst_idwr",  32'(IF_IDWr), 32'd1);
        chk("rst_flush", 32'(IDEXE_Flush), 32'd0);
        chk("rst_busy",  busy_vec, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        cyc();
        resetn = 1'b1;
        idle(1);

        // load r5 lat 1, consumer reads r5 on operand 1
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 3'd1);
        @(negedge clk);
        chk("ld_issue_pcwr", 32'(IF_PCWr), 32'd1);
        cyc();
        drive(1'b1, 5'd5, 5'd1, 2'b10, 1'b0, 5'd0, 3'd0);
        stall_run(5, n, nf, hist);
        chk("ld_stalls", 32'(n), 32'd1);
        chk("ld_flushes", 32'(nf), 32'd1);
        chk("ld_busy5", 32'(hist), 32'h01);
        chk("ld_stall_cnt", stall_cnt, 32'd1);
        cyc();

        // div r7 lat 4, consumer reads r7 on rt
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 3'd4);
        cyc();
        drive(1'b1, 5'd7, 5'd2, 2'b10, 1'b0, 5'd0, 3'd0);
        stall_run(7, n, nf, hist);
        chk("div_stalls", 32'(n), 32'd4);
        chk("div_busy7", 32'(hist), 32'h0F);
        chk("div_stall_cnt", stall_cnt, 32'd5);
        cyc();

        // producer to r0 never blocks
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 3'd3);
        cyc();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 3'd0);
        stall_run(0, n, nf, hist);
        chk("r0_stalls", 32'(n), 32'd0);
        chk("r0_busy", busy_vec, 32'd0);
        cyc();

        // r9 pending: invalid ID and unread operands must not stall
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 3'd3);
        cyc();
        drive(1'b0, 5'd9, 5'd9, 2'b11, 1'b0, 5'd0, 3'd0);
        @(negedge clk);
        chk("inv_pcwr", 32'(IF_PCWr), 32'd1);
        chk("inv_busy9", 32'(busy_vec[9]), 32'd1);
        cyc();
        drive(1'b1, 5'd9, 5'd9, 2'b00, 1'b0, 5'd0, 3'd0);
        stall_run(9, n, nf, hist);
        chk("unread_stalls", 32'(n), 32'd0);
        cyc();
        idle(3);
        chk("drain_busy", busy_vec, 32'd0);

        // WAW: r3 lat 5 then r3 lat 1 leaves 4
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 3'd5);
        cyc();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 3'd1);
        cyc();
        chk("waw_cnt3", 32'(dut.cnt_q[3]), 32'd4);
        drive(1'b1, 5'd0, 5'd3, 2'b01, 1'b0, 5'd0, 3'd0);
        stall_run(3, n, nf, hist);
        chk("waw_stalls", 32'(n), 32'd4);
        chk("waw_stall_cnt", stall_cnt, 32'd9);
        cyc();

        // load-use on r4 with two held cycles
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 3'd1);
        cyc();
        drive(1'b1, 5'd0, 5'd4, 2'b01, 1'b0, 5'd0, 3'd0);
        pipe_hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_pcwr", 32'(IF_PCWr), 32'd0);
            chk("hold_flush", 32'(IDEXE_Flush), 32'd0);
            cyc();
        end
        chk("hold_cnt4", 32'(dut.cnt_q[4]), 32'd1);
        chk("hold_stall_cnt", stall_cnt, 32'd9);
        pipe_hold = 1'b0;
        stall_run(4, n, nf, hist);
        chk("hold_total", 32'(n + 2), 32'd3);
        chk("hold_stall_cnt2", stall_cnt, 32'd10);
        cyc();

        // flush clears a pending r4
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 3'd3);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 3'd0);
        pipe_flush = 1'b1;
        @(negedge clk);
        chk("pre_flush_busy4", 32'(busy_vec[4]), 32'd1);
        cyc();
        pipe_flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy_vec, 32'd0);
        cyc();

        // async reset mid-stall on r6
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 3'd2);
        cyc();
        drive(1'b1, 5'd0, 5'd6, 2'b01, 1'b0, 5'd0, 3'd0);
        @(negedge clk);
        chk("ar_pre_pcwr", 32'(IF_PCWr), 32'd0);
        chk("ar_pre_cnt6", 32'(dut.cnt_q[6]), 32'd2);
        chk("ar_pre_stall_cnt", stall_cnt, 32'd10);
        #1 resetn = 1'b0;
        #1;
        chk("ar_pcwr",  32'(IF_PCWr), 32'd1);
        chk("ar_idwr",  32'(IF_IDWr), 32'd1);
        chk("ar_flush", 32'(IDEXE_Flush), 32'd0);
        chk("ar_busy",  busy_vec, 32'd0);
        chk("ar_stall_cnt", stall_cnt, 32'd0);
        cyc();
        resetn = 1'b1;
        idle(2);
        chk("post_rst_stall_cnt", stall_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
